// File: rtl/updown_counter_core.sv
// Loadable up/down counter with valid/ready load port, wrap or saturate
// limits, and registered terminal-count / load-error pulses.
module updown_counter_core #(
  parameter int BIT_WIDTH  = 4,
  parameter int LOAD_WIDTH = 8,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  chnge,
  input  logic [LOAD_WIDTH-1:0] load,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [BIT_WIDTH-1:0]  count,
  output logic                  tc,
  output logic                  load_err,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [BIT_WIDTH-1:0]  MAX    = '1;
  localparam logic [LOAD_WIDTH-1:0] MAX_LD = LOAD_WIDTH'(MAX);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIT_WIDTH-1:0] r_count;
  logic [BIT_WIDTH-1:0] w_count_nxt;
  logic                 r_tc;
  logic                 w_tc_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 r_ready;

  logic                 w_accept;
  logic [BIT_WIDTH-1:0] w_lim;
  logic                 w_at_lim;
  logic [BIT_WIDTH-1:0] w_step;

  assign w_accept = load_valid & r_ready;
  assign w_lim    = chnge ? MAX : '0;
  assign w_at_lim = (r_count == w_lim);
  assign w_step   = chnge ? r_count + BIT_WIDTH'(1)
                          : r_count - BIT_WIDTH'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_accept) begin
      w_state_nxt = S_LOAD;
      w_count_nxt = load[BIT_WIDTH-1:0];
      w_err_nxt   = (load > MAX_LD);
    end else begin
      unique case (r_state)
        S_IDLE, S_HOLD: begin
          if (en) w_state_nxt = S_COUNT;
        end
        S_LOAD: begin
          w_state_nxt = en ? S_COUNT : S_HOLD;
        end
        S_COUNT: begin
          if (!en) begin
            w_state_nxt = S_HOLD;
          end else if (!(SATURATE && w_at_lim)) begin
            w_count_nxt = w_step;
            // wrap: pulse on leaving the limit; saturate: on arriving
            w_tc_nxt    = SATURATE ? (w_step == w_lim) : w_at_lim;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_err   <= w_err_nxt;
      r_ready <= (w_state_nxt != S_LOAD);
    end
  end

  assign state      = r_state;
  assign count      = r_count;
  assign tc         = r_tc;
  assign load_err   = r_err;
  assign load_ready = r_ready;

endmodule

// File: tb/tb_updown_counter_core.sv
// Bench for updown_counter_core: wrap and saturate instances share
// stimulus, each checked against its own arithmetic reference model.
module tb_updown_counter_core;

  localparam int BW   = 4;
  localparam int LW   = 8;
  localparam int MAXV = (1 << BW) - 1;
  localparam int ST_IDLE  = 0;
  localparam int ST_LOAD  = 1;
  localparam int ST_COUNT = 2;
  localparam int ST_HOLD  = 3;

  logic          CLK = 1'b0;
  logic          reset;
  logic          en;
  logic          chnge;
  logic [LW-1:0] load;
  logic          load_valid;

  logic          rdy_o [2];
  logic [BW-1:0] cnt_o [2];
  logic          tc_o  [2];
  logic          err_o [2];
  logic [1:0]    st_o  [2];

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";

  int m_cnt [2];
  int m_st  [2];
  int m_tc  [2];
  int m_err [2];
  int m_rdy [2];

  updown_counter_core #(
    .BIT_WIDTH(BW), .LOAD_WIDTH(LW), .SATURATE(1'b0)
  ) u_wrap (
    .CLK(CLK), .reset(reset), .en(en), .chnge(chnge),
    .load(load), .load_valid(load_valid),
    .load_ready(rdy_o[0]), .count(cnt_o[0]), .tc(tc_o[0]),
    .load_err(err_o[0]), .state(st_o[0])
  );

  updown_counter_core #(
    .BIT_WIDTH(BW), .LOAD_WIDTH(LW), .SATURATE(1'b1)
  ) u_sat (
    .CLK(CLK), .reset(reset), .en(en), .chnge(chnge),
    .load(load), .load_valid(load_valid),
    .load_ready(rdy_o[1]), .count(cnt_o[1]), .tc(tc_o[1]),
    .load_err(err_o[1]), .state(st_o[1])
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_st[i] = ST_IDLE;
      m_tc[i] = 0; m_err[i] = 0; m_rdy[i] = 0;
    end
  endtask

  // One rising edge of the behavioural model, from the written rules.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int sat;
      int ld;
      sat = i;
      ld  = int'(load);
      m_tc[i]  = 0;
      m_err[i] = 0;
      if (load_valid && m_rdy[i] != 0) begin
        m_cnt[i] = ld % (MAXV + 1);
        m_err[i] = (ld > MAXV) ? 1 : 0;
        m_st[i]  = ST_LOAD;
      end else if (m_st[i] == ST_LOAD) begin
        m_st[i] = en ? ST_COUNT : ST_HOLD;
      end else if (m_st[i] == ST_COUNT && en) begin
        if (chnge) begin
          if (m_cnt[i] == MAXV) begin
            if (sat == 0) begin m_cnt[i] = 0; m_tc[i] = 1; end
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
            if (sat != 0 && m_cnt[i] == MAXV) m_tc[i] = 1;
          end
        end else begin
          if (m_cnt[i] == 0) begin
            if (sat == 0) begin m_cnt[i] = MAXV; m_tc[i] = 1; end
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
            if (sat != 0 && m_cnt[i] == 0) m_tc[i] = 1;
          end
        end
      end else if (m_st[i] == ST_COUNT) begin
        m_st[i] = ST_HOLD;
      end else if (en) begin
        m_st[i] = ST_COUNT;
      end
      m_rdy[i] = (m_st[i] == ST_LOAD) ? 0 : 1;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string nm;
      nm = $sformatf("%s.%s", phase, (i == 0) ? "wrap" : "sat");
      chk({nm, ".count"}, 32'(cnt_o[i]), m_cnt[i]);
      chk({nm, ".state"}, 32'(st_o[i]), m_st[i]);
      chk({nm, ".tc"}, 32'(tc_o[i]), m_tc[i]);
      chk({nm, ".load_err"}, 32'(err_o[i]), m_err[i]);
      chk({nm, ".load_ready"}, 32'(rdy_o[i]), m_rdy[i]);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; chnge = 1'b0;
    load_valid = 1'b0; load = '0;
    model_reset();

    phase = "t1_reset";
    repeat (3) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("t1.ready_lit", 32'(rdy_o[0]), 1);
    chk("t1.state_lit", 32'(st_o[0]), ST_IDLE);

    phase = "t2_wrap_up";
    load = 8'd12; load_valid = 1'b1; en = 1'b1; chnge = 1'b1;
    cyc();
    load_valid = 1'b0;
    chk("t2.count_lit", 32'(cnt_o[0]), 12);
    chk("t2.state_lit", 32'(st_o[0]), ST_LOAD);
    repeat (7) cyc();

    phase = "t3_err_down";
    load = 8'd100; load_valid = 1'b1;
    cyc();
    load_valid = 1'b0;
    chk("t3.count_lit", 32'(cnt_o[0]), 4);
    chk("t3.err_lit", 32'(err_o[0]), 1);
    chnge = 1'b0;
    repeat (7) cyc();

    phase = "t4_sat";
    load = 8'd14; load_valid = 1'b1; chnge = 1'b1; en = 1'b1;
    cyc();
    load_valid = 1'b0;
    repeat (8) cyc();
    chk("t4.pinned_lit", 32'(cnt_o[1]), MAXV);
    chnge = 1'b0;
    repeat (3) cyc();

    phase = "t5_load_prio";
    load = 8'd5; load_valid = 1'b1; chnge = 1'b1; en = 1'b1;
    cyc();
    load_valid = 1'b0;
    repeat (3) cyc();
    chk("t5.at7_lit", 32'(cnt_o[0]), 7);
    load = 8'd3; load_valid = 1'b1;
    cyc();
    load_valid = 1'b0;
    chk("t5.count_lit", 32'(cnt_o[0]), 3);
    chk("t5.state_lit", 32'(st_o[0]), ST_LOAD);
    en = 1'b0;
    repeat (4) cyc();
    chk("t5.hold_lit", 32'(st_o[0]), ST_HOLD);

    phase = "t5b_back2back";
    load = 8'd2; load_valid = 1'b1;
    repeat (4) cyc();
    load_valid = 1'b0;

    phase = "t6_async";
    load = 8'd7; load_valid = 1'b1; en = 1'b1; chnge = 1'b1;
    cyc();
    load_valid = 1'b0;
    repeat (3) cyc();
    chk("t6.at9_lit", 32'(cnt_o[0]), 9);
    #3 reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("t6.async_cnt_lit", 32'(cnt_o[0]), 0);
    chk("t6.async_st_lit", 32'(st_o[0]), ST_IDLE);
    cyc();
    reset = 1'b0; en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    repeat (3) cyc();

    phase = "rand";
    repeat (400) begin
      reset      = ($urandom_range(0, 99) < 2);
      en         = ($urandom_range(0, 3) != 0);
      chnge      = 1'($urandom_range(0, 1));
      load_valid = ($urandom_range(0, 4) == 0);
      load       = LW'($urandom_range(0, 255));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
